// File: rtl/m_dram_addr_demux.sv
// DRAM row/column address demultiplexer: rebuilds {row, column} from the
// multiplexed MA bus using the RAS/CAS/WE strobes and reports access/refresh events.
module m_dram_addr_demux #(
  parameter int AW = 10
) (
  input  logic            MasterClock,
  input  logic            Reset,
  input  logic [AW-1:0]   MA,
  input  logic            RASL,
  input  logic            CASL,
  input  logic            WEL,
  output logic [2*AW-1:0] Address,
  output logic            AddrValid,
  output logic            WriteCycle,
  output logic            PageHit,
  output logic            RefreshCycle,
  output logic            RowOpen
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CBR     = 3'd1,
    ROW     = 3'd2,
    ACCESS  = 3'd3,
    REFRESH = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic              rasl_q, casl_q;
  logic              ras_armed_reg, cas_armed_reg;
  logic [AW-1:0]     row_reg, row_next;
  logic              first_col_reg, first_col_next;
  logic [2*AW-1:0]   address_reg, address_next;
  logic              write_cycle_reg, write_cycle_next;
  logic              page_hit_reg, page_hit_next;
  logic              addr_valid_reg, addr_valid_next;
  logic              refresh_cycle_reg, refresh_cycle_next;

  logic ras_fall, ras_rise, cas_fall, cas_rise;

  // A strobe must be seen high once after reset before its fall counts,
  // so a strobe still low at reset release never produces an event.
  assign ras_fall = ras_armed_reg & rasl_q & ~RASL;
  assign cas_fall = cas_armed_reg & casl_q & ~CASL;
  assign ras_rise = ~rasl_q & RASL;
  assign cas_rise = ~casl_q & CASL;

  always_comb begin
    state_next         = state_reg;
    row_next           = row_reg;
    first_col_next     = first_col_reg;
    address_next       = address_reg;
    write_cycle_next   = write_cycle_reg;
    page_hit_next      = page_hit_reg;
    addr_valid_next    = 1'b0;
    refresh_cycle_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (ras_fall && cas_fall) begin
          refresh_cycle_next = 1'b1;
          state_next         = REFRESH;
        end else if (ras_fall && CASL) begin
          row_next       = MA;
          first_col_next = 1'b1;
          state_next     = ROW;
        end else if (cas_fall && RASL) begin
          state_next = CBR;
        end
      end

      CBR: begin
        if (ras_fall) begin
          refresh_cycle_next = 1'b1;
          state_next         = REFRESH;
        end else if (cas_rise) begin
          state_next = IDLE;
        end
      end

      REFRESH: begin
        if (RASL && CASL) begin
          state_next = IDLE;
        end
      end

      ROW: begin
        // Closing the row wins over a coincident column strobe.
        if (ras_rise) begin
          state_next = IDLE;
        end else if (cas_fall) begin
          address_next     = {row_reg, MA};
          write_cycle_next = ~WEL;
          page_hit_next    = ~first_col_reg;
          first_col_next   = 1'b0;
          addr_valid_next  = 1'b1;
          state_next       = ACCESS;
        end
      end

      ACCESS: begin
        if (ras_rise) begin
          state_next = IDLE;
        end else if (cas_rise) begin
          state_next = ROW;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      state_reg         <= IDLE;
      rasl_q            <= 1'b1;
      casl_q            <= 1'b1;
      ras_armed_reg     <= 1'b0;
      cas_armed_reg     <= 1'b0;
      row_reg           <= '0;
      first_col_reg     <= 1'b0;
      address_reg       <= '0;
      write_cycle_reg   <= 1'b0;
      page_hit_reg      <= 1'b0;
      addr_valid_reg    <= 1'b0;
      refresh_cycle_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      rasl_q            <= RASL;
      casl_q            <= CASL;
      ras_armed_reg     <= ras_armed_reg | RASL;
      cas_armed_reg     <= cas_armed_reg | CASL;
      row_reg           <= row_next;
      first_col_reg     <= first_col_next;
      address_reg       <= address_next;
      write_cycle_reg   <= write_cycle_next;
      page_hit_reg      <= page_hit_next;
      addr_valid_reg    <= addr_valid_next;
      refresh_cycle_reg <= refresh_cycle_next;
    end
  end

  assign Address      = address_reg;
  assign AddrValid    = addr_valid_reg;
  assign WriteCycle   = write_cycle_reg;
  assign PageHit      = page_hit_reg;
  assign RefreshCycle = refresh_cycle_reg;
  assign RowOpen      = (state_reg == ROW) || (state_reg == ACCESS);

endmodule
